// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and lock supervisor.
// Runs entirely on the PLL reference clock so it stays alive while the PLL is
// unlocked. It sequences PLL reset and bypass, qualifies lock over a stability
// window, retries on lock timeout, and releases downstream resets in a
// staggered order.
module pll_lock_supervisor #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES         = 3,
    parameter int NUM_RST_OUT         = 2,
    parameter int STAGGER_CYCLES      = 8
) (
    input  logic                   REFERENCECLK,
    input  logic                   RESETB,
    input  logic                   PLL_LOCK,
    input  logic                   BYPASS_REQ,
    input  logic                   CLEAR_FAULT,
    output logic                   PLL_RESETB,
    output logic                   PLL_BYPASS,
    output logic [NUM_RST_OUT-1:0] RST_OUT_N,
    output logic                   LOCKED,
    output logic                   FAULT,
    output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1)-1:0] RETRY_COUNT,
    output logic [7:0]             LOST_LOCK_CNT,
    output logic [2:0]             STATE
);

    localparam int RETRY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int HOLD_W    = $clog2(RST_HOLD_CYCLES) + 1;
    localparam int TMO_W     = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int STAB_W    = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam int STAG_LAST = 1 + (NUM_RST_OUT - 1) * STAGGER_CYCLES;
    localparam int STAG_W    = $clog2(STAG_LAST) + 1;

    localparam logic [HOLD_W-1:0]  HOLD_END  = HOLD_W'(RST_HOLD_CYCLES);
    localparam logic [TMO_W-1:0]   TMO_END   = TMO_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [STAB_W-1:0]  STAB_END  = STAB_W'(LOCK_STABLE_CYCLES);
    localparam logic [STAG_W-1:0]  STAG_END  = STAG_W'(STAG_LAST);
    localparam logic [RETRY_W-1:0] RETRY_END = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4,
        ST_BYPASS    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 lock_meta_q, lock_s_q;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d, hold_inc;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d, tmo_inc;
    logic [STAB_W-1:0]    stab_cnt_q, stab_cnt_d, stab_inc;
    logic [STAG_W-1:0]    stag_cnt_q, stag_cnt_d, stag_inc;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [7:0]           lost_q, lost_d;
    logic                 pll_resetb_q, pll_resetb_d;
    logic                 pll_bypass_q, pll_bypass_d;
    logic                 locked_q, locked_d;
    logic                 fault_q, fault_d;
    logic [NUM_RST_OUT-1:0] rst_out_n_q, rst_out_n_d;
    logic                 release_ok;

    // Two-flop synchroniser bringing the asynchronous PLL lock into this domain
    always_ff @(posedge REFERENCECLK or negedge RESETB) begin
        if (!RESETB) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= PLL_LOCK;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state logic: bypass beats everything, then fault clear, then timeout/lock events
    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        lost_d     = lost_q;
        hold_cnt_d = '0;
        tmo_cnt_d  = '0;
        stab_cnt_d = '0;
        hold_inc   = hold_cnt_q + 1'b1;
        tmo_inc    = tmo_cnt_q + 1'b1;
        stab_inc   = stab_cnt_q + 1'b1;

        if (BYPASS_REQ && (state_q != ST_BYPASS)) begin
            state_d = ST_BYPASS;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_inc == HOLD_END) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        hold_cnt_d = hold_inc;
                    end
                end
                ST_WAIT_LOCK, ST_STABLE: begin
                    tmo_cnt_d = tmo_inc;
                    if (tmo_inc == TMO_END) begin
                        tmo_cnt_d = '0;
                        if (retry_q == RETRY_END) begin
                            state_d = ST_FAULT;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = ST_HOLD;
                        end
                    end else if (state_q == ST_WAIT_LOCK) begin
                        if (lock_s_q) begin
                            if (STAB_END == STAB_W'(1)) begin
                                state_d = ST_RUN;
                            end else begin
                                state_d    = ST_STABLE;
                                stab_cnt_d = STAB_W'(1);
                            end
                        end
                    end else begin
                        if (!lock_s_q) begin
                            state_d = ST_WAIT_LOCK;
                        end else if (stab_inc == STAB_END) begin
                            state_d = ST_RUN;
                        end else begin
                            stab_cnt_d = stab_inc;
                        end
                    end
                end
                ST_RUN: begin
                    if (!lock_s_q) begin
                        state_d = ST_HOLD;
                        retry_d = '0;
                        lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
                    end
                end
                ST_FAULT: begin
                    if (CLEAR_FAULT) begin
                        state_d = ST_HOLD;
                        retry_d = '0;
                    end
                end
                ST_BYPASS: begin
                    if (!BYPASS_REQ) begin
                        state_d = ST_HOLD;
                        retry_d = '0;
                    end
                end
                default: state_d = ST_HOLD;
            endcase
        end
    end

    // Output decode from the next state; the stagger counter restarts on every RUN/BYPASS entry
    always_comb begin
        stag_inc   = (stag_cnt_q == STAG_END) ? stag_cnt_q : stag_cnt_q + 1'b1;
        release_ok = (state_d == ST_RUN) || (state_d == ST_BYPASS);
        stag_cnt_d = (release_ok && (state_d == state_q)) ? stag_inc : '0;

        pll_resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
        pll_bypass_d = (state_d == ST_BYPASS);
        locked_d     = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);
        rst_out_n_d  = '0;
        for (int i = 0; i < NUM_RST_OUT; i++) begin
            rst_out_n_d[i] = release_ok && (stag_cnt_d >= STAG_W'(1 + i * STAGGER_CYCLES));
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge REFERENCECLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            stab_cnt_q   <= '0;
            stag_cnt_q   <= '0;
            retry_q      <= '0;
            lost_q       <= '0;
            pll_resetb_q <= 1'b0;
            pll_bypass_q <= 1'b0;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
            rst_out_n_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            stab_cnt_q   <= stab_cnt_d;
            stag_cnt_q   <= stag_cnt_d;
            retry_q      <= retry_d;
            lost_q       <= lost_d;
            pll_resetb_q <= pll_resetb_d;
            pll_bypass_q <= pll_bypass_d;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
            rst_out_n_q  <= rst_out_n_d;
        end
    end

    assign PLL_RESETB    = pll_resetb_q;
    assign PLL_BYPASS    = pll_bypass_q;
    assign RST_OUT_N     = rst_out_n_q;
    assign LOCKED        = locked_q;
    assign FAULT         = fault_q;
    assign RETRY_COUNT   = retry_q;
    assign LOST_LOCK_CNT = lost_q;
    assign STATE         = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed testbench for pll_lock_supervisor with small parameters.
// Status vector obs = {STATE, PLL_RESETB, PLL_BYPASS, LOCKED, FAULT, RST_OUT_N}.
module tb_pll_lock_supervisor;

    logic       clk;
    logic       RESETB;
    logic       PLL_LOCK;
    logic       BYPASS_REQ;
    logic       CLEAR_FAULT;
    logic       PLL_RESETB;
    logic       PLL_BYPASS;
    logic [2:0] RST_OUT_N;
    logic       LOCKED;
    logic       FAULT;
    logic [1:0] RETRY_COUNT;
    logic [7:0] LOST_LOCK_CNT;
    logic [2:0] STATE;
    logic [9:0] obs;

    int checks;
    int failures;
    int e;

    pll_lock_supervisor #(
        .RST_HOLD_CYCLES(4), .LOCK_TIMEOUT_CYCLES(32), .LOCK_STABLE_CYCLES(8),
        .MAX_RETRIES(2), .NUM_RST_OUT(3), .STAGGER_CYCLES(4)
    ) dut (
        .REFERENCECLK(clk), .RESETB(RESETB), .PLL_LOCK(PLL_LOCK),
        .BYPASS_REQ(BYPASS_REQ), .CLEAR_FAULT(CLEAR_FAULT),
        .PLL_RESETB(PLL_RESETB), .PLL_BYPASS(PLL_BYPASS), .RST_OUT_N(RST_OUT_N),
        .LOCKED(LOCKED), .FAULT(FAULT), .RETRY_COUNT(RETRY_COUNT),
        .LOST_LOCK_CNT(LOST_LOCK_CNT), .STATE(STATE)
    );

    assign obs = {STATE, PLL_RESETB, PLL_BYPASS, LOCKED, FAULT, RST_OUT_N};

    // Reference clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hold reset for two edges, release on a falling edge; the next rising edge is edge 1
    task automatic do_reset(input logic lock_init);
        RESETB = 1'b0; PLL_LOCK = 1'b0; BYPASS_REQ = 1'b0; CLEAR_FAULT = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        PLL_LOCK = lock_init;
        RESETB   = 1'b1;
        e        = 0;
    endtask

    // Advance to just after rising edge n
    task automatic run_to(input int n);
        while (e < n) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        RESETB = 1'b0; PLL_LOCK = 1'b1; BYPASS_REQ = 1'b0; CLEAR_FAULT = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL reset_status: got %b expected %b", obs, exp); end
        checks++; if (RETRY_COUNT !== 2'd0) begin failures++; $display("[TB] FAIL reset_retry: got %0d expected 0", RETRY_COUNT); end
        checks++; if (LOST_LOCK_CNT !== 8'd0) begin failures++; $display("[TB] FAIL reset_lost: got %0d expected 0", LOST_LOCK_CNT); end
    endtask

    task automatic test_normal_lock();
        logic [9:0] exp;
        do_reset(1'b0);
        run_to(3);
        exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL normal_hold_e3: got %b expected %b", obs, exp); end
        run_to(4);
        exp = {3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL normal_wait_e4: got %b expected %b", obs, exp); end
        run_to(9);
        PLL_LOCK = 1'b1;
        run_to(11);
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL normal_wait_e11: got %b expected %b", obs, exp); end
        run_to(12);
        exp = {3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL normal_stable_e12: got %b expected %b", obs, exp); end
        run_to(18);
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL normal_stable_e18: got %b expected %b", obs, exp); end
        run_to(19);
        exp = {3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL normal_run_e19: got %b expected %b", obs, exp); end
        run_to(20);
        exp = {3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL normal_rel0_e20: got %b expected %b", obs, exp); end
        run_to(23);
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL normal_rel0_e23: got %b expected %b", obs, exp); end
        run_to(24);
        exp = {3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'b011};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL normal_rel1_e24: got %b expected %b", obs, exp); end
        run_to(27);
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL normal_rel1_e27: got %b expected %b", obs, exp); end
        run_to(28);
        exp = {3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'b111};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL normal_rel2_e28: got %b expected %b", obs, exp); end
    endtask

    task automatic test_never_lock();
        logic [9:0] exp;
        do_reset(1'b0);
        run_to(35);
        exp = {3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL never_wait_e35: got %b expected %b", obs, exp); end
        checks++; if (RETRY_COUNT !== 2'd0) begin failures++; $display("[TB] FAIL never_retry_e35: got %0d expected 0", RETRY_COUNT); end
        run_to(36);
        exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL never_hold_e36: got %b expected %b", obs, exp); end
        checks++; if (RETRY_COUNT !== 2'd1) begin failures++; $display("[TB] FAIL never_retry_e36: got %0d expected 1", RETRY_COUNT); end
        run_to(40);
        exp = {3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL never_wait_e40: got %b expected %b", obs, exp); end
        run_to(72);
        checks++; if (RETRY_COUNT !== 2'd2) begin failures++; $display("[TB] FAIL never_retry_e72: got %0d expected 2", RETRY_COUNT); end
        run_to(107);
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL never_wait_e107: got %b expected %b", obs, exp); end
        run_to(108);
        exp = {3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL never_fault_e108: got %b expected %b", obs, exp); end
        checks++; if (RETRY_COUNT !== 2'd2) begin failures++; $display("[TB] FAIL never_retry_e108: got %0d expected 2", RETRY_COUNT); end
        run_to(110);
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL never_fault_e110: got %b expected %b", obs, exp); end
        CLEAR_FAULT = 1'b1;
        run_to(111);
        CLEAR_FAULT = 1'b0;
        exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL never_clear_e111: got %b expected %b", obs, exp); end
        checks++; if (RETRY_COUNT !== 2'd0) begin failures++; $display("[TB] FAIL never_clear_retry: got %0d expected 0", RETRY_COUNT); end
    endtask

    // PLL_LOCK sampled at edge k is ((k/5)%2 == 1): high for edges 5-9, 15-19, ...
    task automatic test_chatter();
        logic [9:0] exp;
        logic       chk;
        do_reset(1'b0);
        for (int k = 1; k <= 36; k++) begin
            run_to(k);
            PLL_LOCK = (((k + 1) / 5) % 2) == 1;
            chk = 1'b1;
            case (k)
                7, 11, 17, 27:  exp = {3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
                12, 22, 32, 35: exp = {3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
                36:             exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
                default: begin exp = '0; chk = 1'b0; end
            endcase
            if (chk) begin
                checks++;
                if (obs !== exp) begin failures++; $display("[TB] FAIL chatter_e%0d: got %b expected %b", k, obs, exp); end
            end
        end
        checks++; if (RETRY_COUNT !== 2'd1) begin failures++; $display("[TB] FAIL chatter_retry: got %0d expected 1", RETRY_COUNT); end
    endtask

    task automatic test_loss_in_run();
        logic [9:0] exp;
        do_reset(1'b1);
        run_to(5);
        exp = {3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL loss_stable_e5: got %b expected %b", obs, exp); end
        run_to(12);
        exp = {3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL loss_run_e12: got %b expected %b", obs, exp); end
        run_to(21);
        exp = {3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'b111};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL loss_full_e21: got %b expected %b", obs, exp); end
        CLEAR_FAULT = 1'b1;
        run_to(22);
        CLEAR_FAULT = 1'b0;
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL loss_clear_ignored: got %b expected %b", obs, exp); end
        PLL_LOCK = 1'b0;
        run_to(23);
        PLL_LOCK = 1'b1;
        run_to(24);
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL loss_still_run_e24: got %b expected %b", obs, exp); end
        run_to(25);
        exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL loss_drop_e25: got %b expected %b", obs, exp); end
        checks++; if (LOST_LOCK_CNT !== 8'd1) begin failures++; $display("[TB] FAIL loss_count: got %0d expected 1", LOST_LOCK_CNT); end
        checks++; if (RETRY_COUNT !== 2'd0) begin failures++; $display("[TB] FAIL loss_retry: got %0d expected 0", RETRY_COUNT); end
        run_to(29);
        exp = {3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL loss_rewait_e29: got %b expected %b", obs, exp); end
        run_to(37);
        exp = {3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL loss_rerun_e37: got %b expected %b", obs, exp); end
        checks++; if (LOST_LOCK_CNT !== 8'd1) begin failures++; $display("[TB] FAIL loss_count_e37: got %0d expected 1", LOST_LOCK_CNT); end
    endtask

    task automatic test_bypass();
        logic [9:0] exp;
        do_reset(1'b1);
        run_to(6);
        exp = {3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL bypass_pre_e6: got %b expected %b", obs, exp); end
        BYPASS_REQ = 1'b1;
        run_to(7);
        exp = {3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL bypass_entry_e7: got %b expected %b", obs, exp); end
        run_to(8);
        exp = {3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL bypass_rel0_e8: got %b expected %b", obs, exp); end
        run_to(11);
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL bypass_rel0_e11: got %b expected %b", obs, exp); end
        run_to(12);
        exp = {3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 3'b011};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL bypass_rel1_e12: got %b expected %b", obs, exp); end
        run_to(15);
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL bypass_rel1_e15: got %b expected %b", obs, exp); end
        run_to(16);
        exp = {3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL bypass_rel2_e16: got %b expected %b", obs, exp); end
        run_to(18);
        BYPASS_REQ = 1'b0;
        run_to(19);
        exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL bypass_exit_e19: got %b expected %b", obs, exp); end
        checks++; if (RETRY_COUNT !== 2'd0) begin failures++; $display("[TB] FAIL bypass_exit_retry: got %0d expected 0", RETRY_COUNT); end
    endtask

    task automatic test_async_reset();
        logic [9:0] exp;
        do_reset(1'b1);
        run_to(14);
        exp = {3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL async_pre_e14: got %b expected %b", obs, exp); end
        #2;
        RESETB = 1'b0;
        #1;
        exp = {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
        checks++; if (obs !== exp) begin failures++; $display("[TB] FAIL async_reset_now: got %b expected %b", obs, exp); end
        checks++; if (RETRY_COUNT !== 2'd0) begin failures++; $display("[TB] FAIL async_retry: got %0d expected 0", RETRY_COUNT); end
    endtask

    // Scenario sequence and summary
    initial begin
        checks = 0; failures = 0; e = 0;
        RESETB = 1'b0; PLL_LOCK = 1'b0; BYPASS_REQ = 1'b0; CLEAR_FAULT = 1'b0;
        test_reset();
        test_normal_lock();
        test_never_lock();
        test_chatter();
        test_loss_in_run();
        test_bypass();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
